// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline stage register: occupancy state
// encoding plus payload layouts of the fixed stage boundaries that instantiate it.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // IF/ID boundary: {instr, pc}
    localparam int IF_ID_PC_OFF    = 0;
    localparam int IF_ID_PC_W      = 32;
    localparam int IF_ID_INSTR_OFF = IF_ID_PC_OFF + IF_ID_PC_W;
    localparam int IF_ID_INSTR_W   = 32;
    localparam int IF_ID_W         = IF_ID_INSTR_OFF + IF_ID_INSTR_W;

    // MEM/WB boundary: {reg_write, wb_data, rd}
    localparam int MEM_WB_RD_OFF    = 0;
    localparam int MEM_WB_RD_W      = 5;
    localparam int MEM_WB_WDATA_OFF = MEM_WB_RD_OFF + MEM_WB_RD_W;
    localparam int MEM_WB_WDATA_W   = 32;
    localparam int MEM_WB_REGWR_OFF = MEM_WB_WDATA_OFF + MEM_WB_WDATA_W;
    localparam int MEM_WB_W         = MEM_WB_REGWR_OFF + 1;

    function automatic logic [IF_ID_W-1:0] pack_if_id(
        input logic [IF_ID_INSTR_W-1:0] instr,
        input logic [IF_ID_PC_W-1:0]    pc
    );
        return {instr, pc};
    endfunction

    function automatic logic [MEM_WB_W-1:0] pack_mem_wb(
        input logic                      reg_write,
        input logic [MEM_WB_WDATA_W-1:0] wb_data,
        input logic [MEM_WB_RD_W-1:0]    rd
    );
        return {reg_write, wb_data, rd};
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, flush to a bubble and
// an optional two-entry skid buffer that makes IN_READY a pure register output.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      SKID      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [1:0]       COUNT
);

    stage_state_e     state_reg, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;

    // Gating with RST keeps the handshake quiet even before the first reset edge.
    assign out_valid = (state_reg != ST_EMPTY) && !RST;
    assign in_fire   = IN_VALID && in_ready;
    assign out_fire  = out_valid && OUT_READY;

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid;
    assign OUT_DATA  = main_reg;
    assign COUNT     = RST ? 2'd0 : state_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_EMPTY;
            main_reg  <= RESET_VAL;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] skid_reg, skid_next;
            logic             in_ready_reg;

            always_comb begin
                state_next = state_reg;
                main_next  = main_reg;
                skid_next  = skid_reg;
                if (FLUSH) begin
                    state_next = ST_EMPTY;
                    main_next  = RESET_VAL;
                    skid_next  = RESET_VAL;
                end else begin
                    case (state_reg)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                state_next = ST_ONE;
                                main_next  = IN_DATA;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                main_next = IN_DATA;
                            end else if (in_fire) begin
                                state_next = ST_FULL;
                                skid_next  = IN_DATA;
                            end else if (out_fire) begin
                                state_next = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            // Skid entry is always younger than main, so it moves up only.
                            if (out_fire) begin
                                state_next = ST_ONE;
                                main_next  = skid_reg;
                            end
                        end
                        default: state_next = ST_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    skid_reg     <= RESET_VAL;
                    in_ready_reg <= 1'b1;
                end else begin
                    skid_reg     <= skid_next;
                    in_ready_reg <= (state_next != ST_FULL);
                end
            end

            assign in_ready = in_ready_reg && !RST;
        end else begin : g_single
            always_comb begin
                state_next = state_reg;
                main_next  = main_reg;
                if (FLUSH) begin
                    state_next = ST_EMPTY;
                    main_next  = RESET_VAL;
                end else if (in_fire) begin
                    state_next = ST_ONE;
                    main_next  = IN_DATA;
                end else if (out_fire) begin
                    state_next = ST_EMPTY;
                end
            end

            assign in_ready = (!out_valid || OUT_READY) && !RST;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives one SKID=1 and one SKID=0 stage with shared inputs; a per-instance
// scoreboard tracks accepted payloads and checks order, occupancy and flush loss.
module tb_pipe_stage_reg;

    localparam logic [31:0] RV1 = 32'h0000_0000;
    localparam logic [31:0] RV0 = 32'h0000_5A5A;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        rdy1, ov1, rdy0, ov0;
    logic [31:0] od1, od0;
    logic [1:0]  cnt1, cnt0;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef logic [31:0] q_t[$];
    q_t sb[2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .RESET_VAL(RV1)) dut1 (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(rdy1), .IN_DATA(in_data),
        .OUT_VALID(ov1), .OUT_READY(out_ready), .OUT_DATA(od1), .COUNT(cnt1)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(0), .RESET_VAL(RV0)) dut0 (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(rdy0), .IN_DATA(in_data),
        .OUT_VALID(ov0), .OUT_READY(out_ready), .OUT_DATA(od0), .COUNT(cnt0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs just before each rising edge: compares, then updates the model for that edge.
    task automatic mon_port(input int k, input logic rdy, input logic ov,
                            input logic [31:0] od, input logic [1:0] cnt);
        logic [31:0] exp;
        int          lim;
        lim = (k == 1) ? 2 : 1;
        if (rst) begin
            check($sformatf("rst_in_ready_s%0d", k), {31'd0, rdy}, 32'd0);
            check($sformatf("rst_out_valid_s%0d", k), {31'd0, ov}, 32'd0);
            check($sformatf("rst_count_s%0d", k), {30'd0, cnt}, 32'd0);
            sb[k].delete();
            return;
        end
        check($sformatf("count_vs_model_s%0d", k), {30'd0, cnt}, sb[k].size());
        check($sformatf("count_bound_s%0d", k), {31'd0, (int'(cnt) > lim)}, 32'd0);
        check($sformatf("out_valid_s%0d", k), {31'd0, ov}, {31'd0, sb[k].size() != 0});
        if (ov && out_ready) begin
            exp = (sb[k].size() != 0) ? sb[k].pop_front() : 32'hxxxx_xxxx;
            check($sformatf("out_data_order_s%0d", k), od, exp);
        end
        if (flush)
            sb[k].delete();
        else if (in_valid && rdy)
            sb[k].push_back(in_data);
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            mon_port(1, rdy1, ov1, od1, cnt1);
            mon_port(0, rdy0, ov0, od0, cnt0);
        end
    end

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #3;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
        mon_en = 1'b1;

        // Reset held across two edges with a pending upstream payload
        @(negedge clk); #3;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #3;
        check("post_rst_count_s1", {30'd0, cnt1}, 32'd0);
        check("post_rst_data_s1", od1, RV1);
        check("post_rst_ready_s1", {31'd0, rdy1}, 32'd1);
        check("post_rst_data_s0", od0, RV0);
        check("post_rst_ready_s0", {31'd0, rdy0}, 32'd1);

        // Streaming 1..4
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, 1'b1, 1'b0);
            if (i > 1) begin
                check("stream_data_s1", od1, i - 1);
                check("stream_data_s0", od0, i - 1);
                check("stream_count_s1", {30'd0, cnt1}, 32'd1);
            end
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("stream_last_s1", od1, 32'd4);
        check("stream_last_s0", od0, 32'd4);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("stream_empty_s1", {31'd0, ov1}, 32'd0);

        // Back-pressure: A, B then stall
        drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        check("bp_ready_one_s1", {31'd0, rdy1}, 32'd1);
        check("stall_ready_s0", {31'd0, rdy0}, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("bp_count_full_s1", {30'd0, cnt1}, 32'd2);
        check("bp_ready_full_s1", {31'd0, rdy1}, 32'd0);
        check("bp_hold_a_s1", od1, 32'hAAAA_0001);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("bp_stable_a_s1", od1, 32'hAAAA_0001);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("bp_ready_registered_s1", {31'd0, rdy1}, 32'd0);
        check("stall_release_ready_s0", {31'd0, rdy0}, 32'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("bp_emit_b_s1", od1, 32'hBBBB_0002);
        check("bp_ready_back_s1", {31'd0, rdy1}, 32'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);

        // SKID=0: simultaneous in_fire and out_fire keeps one entry
        drive(1'b1, 32'hC0C0_0000, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("s0_hold_ready", {31'd0, rdy0}, 32'd0);
        drive(1'b1, 32'hC1C1_0001, 1'b1, 1'b0);
        check("s0_both_fire_ready", {31'd0, rdy0}, 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("s0_both_fire_count", {30'd0, cnt0}, 32'd1);
        check("s0_both_fire_data", od0, 32'hC1C1_0001);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush while FULL: A consumed, B and C dropped
        drive(1'b1, 32'hA0A0_0001, 1'b0, 1'b0);
        drive(1'b1, 32'hB0B0_0002, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'hC0C0_0003, 1'b1, 1'b1);
        check("flush_out_a_s1", od1, 32'hA0A0_0001);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("flush_count_s1", {30'd0, cnt1}, 32'd0);
        check("flush_data_s1", od1, RV1);
        check("flush_ready_s1", {31'd0, rdy1}, 32'd1);
        check("flush_count_s0", {30'd0, cnt0}, 32'd0);
        check("flush_data_s0", od0, RV0);

        // Random traffic with an occasional flush and one mid-run reset
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = (n == 300);
        end
        for (int n = 0; n < 4; n++)
            drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("drain_model_s1", sb[1].size(), 32'd0);
        check("drain_model_s0", sb[0].size(), 32'd0);
        check("drain_count_s1", {30'd0, cnt1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
